// File: rtl/vga_rect_fill_if.sv
// rtl/vga_rect_fill_if.sv - control/plot bundle between fill engine and its users
interface vga_rect_fill_if #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOR_W  = 3
);
  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);

  logic               start;
  logic [1:0]         mode;
  logic [COLOR_W-1:0] fill_color;
  logic [XW-1:0]      x0;
  logic [YW-1:0]      y0;
  logic [XW-1:0]      x1;
  logic [YW-1:0]      y1;
  logic               stall;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [COLOR_W-1:0] color;
  logic               plot;
  logic               busy;
  logic               done;

  modport master (
    output start, mode, fill_color, x0, y0, x1, y1, stall,
    input  x, y, color, plot, busy, done
  );

  modport slave (
    input  start, mode, fill_color, x0, y0, x1, y1, stall,
    output x, y, color, plot, busy, done
  );
endinterface

// File: rtl/vga_rect_fill_engine.sv
// rtl/vga_rect_fill_engine.sv - clipped rectangle / screen-clear pixel generator
module vga_rect_fill_engine #(
  parameter int SCREEN_W       = 160,
  parameter int SCREEN_H       = 120,
  parameter int COLOR_W        = 3,
  parameter int STRIPE_SHIFT   = 0,
  parameter int CELL_LOG2      = 3,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic            clk,
  input logic            reset,
  vga_rect_fill_if.slave bus
);
  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);
  // Wide enough that every stripe slice and checker bit lands inside it (zero-extension).
  localparam int EW = XW + YW + STRIPE_SHIFT + COLOR_W + CELL_LOG2 + 1;
  localparam logic [XW-1:0] X_MAX = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_H - 1);
  localparam logic [XW:0]   X_LIM = (XW+1)'(SCREEN_W);
  localparam logic [YW:0]   Y_LIM = (YW+1)'(SCREEN_H);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_FILL, S_DONE} state_t;
  localparam state_t S_RESET = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_t             state_q, state_n;
  logic [XW-1:0]      x_q, x_n, xmin_q, xmin_n, xmax_q, xmax_n, x1c;
  logic [YW-1:0]      y_q, y_n, ymax_q, ymax_n, y1c;
  logic [1:0]         mode_q, mode_n;
  logic [COLOR_W-1:0] fc_q, fc_n, color_q, color_n;
  logic               plot_q, plot_n, empty;

  function automatic logic [COLOR_W-1:0] color_of(
    input logic [1:0] m, input logic [COLOR_W-1:0] fc,
    input logic [XW-1:0] px, input logic [YW-1:0] py);
    logic [EW-1:0] xe, ye;
    xe = EW'(px);
    ye = EW'(py);
    case (m)
      2'd0:    color_of = fc;
      2'd1:    color_of = ye[STRIPE_SHIFT +: COLOR_W];
      2'd2:    color_of = xe[STRIPE_SHIFT +: COLOR_W];
      default: color_of = (xe[CELL_LOG2] ^ ye[CELL_LOG2]) ? fc : '0;
    endcase
  endfunction

  // Clip the requested rectangle against the screen and flag an empty result.
  always_comb begin
    x1c   = (bus.x1 > X_MAX) ? X_MAX : bus.x1;
    y1c   = (bus.y1 > Y_MAX) ? Y_MAX : bus.y1;
    empty = (bus.x0 > x1c) || (bus.y0 > y1c) ||
            ({1'b0, bus.x0} >= X_LIM) || ({1'b0, bus.y0} >= Y_LIM);
  end

  // Next state and next pixel; CLEAR reuses the fill walker with full-screen bounds, colour 0.
  always_comb begin
    state_n = state_q;
    x_n     = x_q;
    y_n     = y_q;
    plot_n  = plot_q;
    xmin_n  = xmin_q;
    xmax_n  = xmax_q;
    ymax_n  = ymax_q;
    mode_n  = mode_q;
    fc_n    = fc_q;
    case (state_q)
      S_CLEAR, S_FILL: begin
        if (!bus.stall) begin
          if (x_q < xmax_q) begin
            x_n = x_q + 1'b1;
          end else if (y_q < ymax_q) begin
            x_n = xmin_q;
            y_n = y_q + 1'b1;
          end else begin
            state_n = S_DONE;
            plot_n  = 1'b0;
          end
        end
      end
      S_IDLE: begin
        plot_n = 1'b0;
        if (bus.start) begin
          mode_n = bus.mode;
          fc_n   = bus.fill_color;
          if (empty) begin
            state_n = S_DONE;
          end else begin
            state_n = S_FILL;
            xmin_n  = bus.x0;
            xmax_n  = x1c;
            ymax_n  = y1c;
            x_n     = bus.x0;
            y_n     = bus.y0;
            plot_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        plot_n  = 1'b0;
      end
    endcase
    color_n = color_of(mode_n, fc_n, x_n, y_n);
  end

  // State, latched request and registered pixel outputs; reset restarts the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      plot_q  <= CLEAR_ON_RESET;
      xmin_q  <= '0;
      xmax_q  <= X_MAX;
      ymax_q  <= Y_MAX;
      mode_q  <= 2'd0;
      fc_q    <= '0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      y_q     <= y_n;
      color_q <= color_n;
      plot_q  <= plot_n;
      xmin_q  <= xmin_n;
      xmax_q  <= xmax_n;
      ymax_q  <= ymax_n;
      mode_q  <= mode_n;
      fc_q    <= fc_n;
    end
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.color = color_q;
  assign bus.plot  = plot_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = (state_q == S_DONE);
endmodule

// File: tb/tb_vga_rect_fill_engine.sv
// tb/tb_vga_rect_fill_engine.sv - self-checking bench for vga_rect_fill_engine
module tb_vga_rect_fill_engine;
  localparam int W = 160;
  localparam int H = 120;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   exp_q[$];
  int   got_q[$];

  vga_rect_fill_if #(.SCREEN_W(W), .SCREEN_H(H), .COLOR_W(3)) bus ();

  vga_rect_fill_engine #(
    .SCREEN_W(W), .SCREEN_H(H), .COLOR_W(3),
    .STRIPE_SHIFT(0), .CELL_LOG2(3), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mode; int fc; int x0; int y0; int x1; int y1;
    int stall_kind; int mid_start; int exp_lat;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_color(int m, int fc, int px, int py);
    case (m)
      0:       return fc;
      1:       return py % 8;
      2:       return px % 8;
      default: return (((px / 8) + (py / 8)) % 2 == 1) ? fc : 0;
    endcase
  endfunction

  function automatic int pack_pix(int px, int py, int c);
    return px * 65536 + py * 256 + c;
  endfunction

  // Expected accepted pixels: every clipped coordinate in raster order.
  task automatic build_model(input vec_t v);
    int xe, ye;
    exp_q.delete();
    xe = (v.x1 > W - 1) ? W - 1 : v.x1;
    ye = (v.y1 > H - 1) ? H - 1 : v.y1;
    for (int yy = v.y0; yy <= ye; yy++)
      for (int xx = v.x0; xx <= xe; xx++)
        exp_q.push_back(pack_pix(xx, yy, ref_color(v.mode, v.fc, xx, yy)));
  endtask

  task automatic drive_req(input vec_t v);
    bus.mode       = 2'(v.mode);
    bus.fill_color = 3'(v.fc);
    bus.x0         = 8'(v.x0);
    bus.y0         = 7'(v.y0);
    bus.x1         = 8'(v.x1);
    bus.y1         = 7'(v.y1);
  endtask

  task automatic run_fill(input string name, input vec_t v);
    int   lat;
    bit   seen_done, hold;
    logic [7:0] hx;
    logic [6:0] hy;
    logic [2:0] hc;
    vec_t other;
    build_model(v);
    got_q.delete();
    @(negedge clk);
    chk({name, "_idle_busy"}, bus.busy, 0);
    drive_req(v);
    bus.stall = 1'b0;
    bus.start = 1'b1;
    lat = 0;
    seen_done = 1'b0;
    hold = 1'b0;
    other = '{0, 1, 0, 0, 5, 5, 0, 0, 0};
    for (int k = 1; k <= 3000 && !seen_done; k++) begin
      @(negedge clk);
      lat++;
      bus.start = (v.mid_start != 0 && k == 3);
      if (v.mid_start != 0 && k == 3) drive_req(other);
      if (v.mid_start != 0 && k == 4) drive_req(v);
      if (hold) begin
        chk({name, "_hold_x"}, bus.x, hx);
        chk({name, "_hold_y"}, bus.y, hy);
        chk({name, "_hold_c"}, bus.color, hc);
        chk({name, "_hold_plot"}, bus.plot, 1);
      end
      case (v.stall_kind)
        1:       bus.stall = (k % 2 == 0);
        2:       bus.stall = ($urandom_range(0, 3) == 0);
        default: bus.stall = 1'b0;
      endcase
      if (bus.done) begin
        seen_done = 1'b1;
        chk({name, "_done_plot"}, bus.plot, 0);
        chk({name, "_done_busy"}, bus.busy, 1);
      end else begin
        if (bus.plot && !bus.stall) got_q.push_back(pack_pix(bus.x, bus.y, bus.color));
        hold = bus.plot && bus.stall;
        hx = bus.x; hy = bus.y; hc = bus.color;
      end
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;
    chk({name, "_done_seen"}, seen_done, 1);
    if (v.exp_lat >= 0) chk({name, "_latency"}, lat, v.exp_lat);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_pixel"}, got_q[i], exp_q[i]);
    @(negedge clk);
    chk({name, "_busy_after"}, bus.busy, 0);
    chk({name, "_done_pulse"}, bus.done, 0);
  endtask

  vec_t vecs[10];

  initial begin
    int errs;
    bit ok;
    n_chk = 0;
    n_fail = 0;
    vecs[0] = '{0, 5, 10, 20, 12, 21, 0, 0, 7};     // solid 3x2
    vecs[1] = '{1, 0, 0, 0, 0, 9, 0, 0, 11};        // row stripe column
    vecs[2] = '{3, 6, 6, 0, 9, 0, 0, 0, 5};         // checker edge
    vecs[3] = '{0, 2, 40, 40, 43, 40, 1, 0, 8};     // stall toggling
    vecs[4] = '{2, 0, 150, 0, 255, 0, 0, 0, 11};    // clipped at right edge
    vecs[5] = '{0, 3, 5, 0, 4, 0, 0, 0, 1};         // x0 > x1 empty
    vecs[6] = '{0, 3, 170, 0, 200, 0, 0, 0, 1};     // x0 off screen
    vecs[7] = '{0, 3, 0, 125, 3, 127, 0, 0, 1};     // y0 off screen
    vecs[8] = '{0, 4, 20, 30, 23, 31, 0, 1, 9};     // start pulsed mid-fill
    vecs[9] = '{3, 7, 155, 115, 200, 127, 0, 0, 26};// corner clip, checker

    reset = 1'b0;
    bus.start = 1'b0; bus.stall = 1'b0; bus.mode = 2'd0; bus.fill_color = 3'd0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;

    @(negedge clk);
    chk("rst_x", bus.x, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_color", bus.color, 0);
    chk("rst_plot", bus.plot, 1);
    chk("rst_busy", bus.busy, 1);
    chk("rst_done", bus.done, 0);
    reset = 1'b1;

    errs = 0;
    for (int i = 0; i < W * H; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.plot !== 1'b1 || bus.x !== 8'(i % W) || bus.y !== 7'(i / W) ||
          bus.color !== 3'd0 || bus.done !== 1'b0)
        errs++;
    end
    chk("clear_raster_errors", errs, 0);
    @(negedge clk);
    chk("clear_done", bus.done, 1);
    chk("clear_done_plot", bus.plot, 0);
    @(negedge clk);
    chk("clear_busy_low", bus.busy, 0);
    chk("clear_done_low", bus.done, 0);

    foreach (vecs[i]) run_fill($sformatf("vec%0d", i), vecs[i]);

    for (int r = 0; r < 20; r++) begin
      vec_t rv;
      rv.mode = $urandom_range(0, 3);
      rv.fc = $urandom_range(0, 7);
      rv.x0 = $urandom_range(0, 170);
      rv.y0 = $urandom_range(0, 125);
      rv.x1 = rv.x0 + $urandom_range(0, 20) - 2;
      rv.y1 = rv.y0 + $urandom_range(0, 5) - 1;
      if (rv.x1 < 0) rv.x1 = 0;
      if (rv.x1 > 255) rv.x1 = 255;
      if (rv.y1 < 0) rv.y1 = 0;
      if (rv.y1 > 127) rv.y1 = 127;
      rv.stall_kind = (r % 2 == 0) ? 2 : 0;
      rv.mid_start = 0;
      rv.exp_lat = -1;
      run_fill($sformatf("rand%0d", r), rv);
    end

    // Reset asserted in the middle of a fill aborts at once and restarts the clear.
    @(negedge clk);
    drive_req('{0, 5, 0, 0, 50, 50, 0, 0, 0});
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_fill_plot", bus.plot, 1);
    reset = 1'b0;
    #1;
    chk("abort_x", bus.x, 0);
    chk("abort_y", bus.y, 0);
    chk("abort_color", bus.color, 0);
    chk("abort_plot", bus.plot, 1);
    chk("abort_busy", bus.busy, 1);
    chk("abort_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b1;
    chk("reclear_x0", bus.x, 0);
    @(negedge clk);
    chk("reclear_x1", bus.x, 1);
    chk("reclear_y", bus.y, 0);
    ok = 1'b0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk);
      if (bus.done) ok = 1'b1;
    end
    chk("reclear_done_seen", ok, 1);
    @(negedge clk);
    chk("reclear_busy_low", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
